// File: rtl/write_qos_arbiter.sv
`timescale 1ns/1ps
// Shared write-channel arbiter: picks the requester with the highest effective QoS,
// breaks ties round-robin, and holds the winner until the transaction's token.
module write_qos_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int ID_WIDTH     = $clog2(NUM_REQ),
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0][3:0]  qos,
  input  logic                     token,
  input  logic                     channel_granted,
  output logic                     channel_request,
  output logic [ID_WIDTH-1:0]      selected_slave,
  output logic [NUM_REQ-1:0]       grant_vec
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;

  state_t              state, state_next;
  logic                latch_win, complete;
  logic [ID_WIDTH-1:0] rr_ptr, win_idx;
  logic [CW-1:0]       starve_cnt [NUM_REQ];
  logic [3:0]          eqos [NUM_REQ];
  logic [3:0]          best_qos;
  logic                found;

  // A requester that has lost STARVE_LIMIT times in a row competes at QoS 15.
  always_comb begin
    int j;
    j        = 0;
    best_qos = '0;
    win_idx  = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eqos[i] = (starve_cnt[i] == CW'(STARVE_LIMIT)) ? 4'hF : qos[i];
      if (req[i] && (eqos[i] > best_qos))
        best_qos = eqos[i];
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ)
        j = j - NUM_REQ;
      if (!found && req[j] && (eqos[j] == best_qos)) begin
        win_idx = ID_WIDTH'(j);
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    latch_win  = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          latch_win  = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (channel_granted && token) begin
          complete   = 1'b1;
          state_next = IDLE;
        end else if (channel_granted) begin
          state_next = BUSY;
        end else if (!req[selected_slave]) begin
          state_next = IDLE;
        end
      end
      BUSY: begin
        if (token) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Outputs are registered from the next state so nothing combinational reaches a port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      channel_request <= 1'b0;
      selected_slave  <= '0;
      grant_vec       <= '0;
      rr_ptr          <= '0;
      for (int i = 0; i < NUM_REQ; i++)
        starve_cnt[i] <= '0;
    end else begin
      channel_request <= (state_next == REQ);
      if (latch_win) begin
        selected_slave <= win_idx;
        grant_vec      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (ID_WIDTH'(i) == win_idx)
            starve_cnt[i] <= '0;
          else if (req[i] && (starve_cnt[i] != CW'(STARVE_LIMIT)))
            starve_cnt[i] <= starve_cnt[i] + CW'(1);
        end
      end else if (state_next == IDLE) begin
        grant_vec <= '0;
      end
      if (complete)
        rr_ptr <= (selected_slave == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                             : selected_slave + ID_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_write_qos_arbiter.sv
`timescale 1ns/1ps
// Directed bench for write_qos_arbiter: a 2-requester instance with STARVE_LIMIT=2
// and a 4-requester instance with the default limit, sharing clock and reset.
module tb_write_qos_arbiter;

  logic clk = 1'b0;
  logic reset_n;

  logic [1:0]      req2;
  logic [1:0][3:0] qos2;
  logic            tok2, cg2, cr2;
  logic            sel2;
  logic [1:0]      gv2;

  logic [3:0]      req4;
  logic [3:0][3:0] qos4;
  logic            tok4, cg4, cr4;
  logic [1:0]      sel4;
  logic [3:0]      gv4;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  write_qos_arbiter #(.NUM_REQ(2), .STARVE_LIMIT(2)) d2 (
    .clk(clk), .reset_n(reset_n), .req(req2), .qos(qos2), .token(tok2),
    .channel_granted(cg2), .channel_request(cr2), .selected_slave(sel2), .grant_vec(gv2)
  );

  write_qos_arbiter #(.NUM_REQ(4)) d4 (
    .clk(clk), .reset_n(reset_n), .req(req4), .qos(qos4), .token(tok4),
    .channel_granted(cg4), .channel_request(cr4), .selected_slave(sel4), .grant_vec(gv4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req2 = '0; qos2 = '0; tok2 = 1'b0; cg2 = 1'b0;
    req4 = '0; qos4 = '0; tok4 = 1'b0; cg4 = 1'b0;
    repeat (2) tick();
    vectors++;
    if ({cr2, sel2, gv2} !== 4'b0) begin
      miscompares++; $display("[TB] FAIL por_d2: got %b expected 0000", {cr2, sel2, gv2});
    end
    vectors++;
    if ({cr4, sel4, gv4} !== 7'b0) begin
      miscompares++; $display("[TB] FAIL por_d4: got %b expected 0000000", {cr4, sel4, gv4});
    end
    reset_n = 1'b1;
    qos2[1] = 4'd9;
    req2 = 2'b10;
    tick();
    cg2 = 1'b1;
    tick();
    cg2 = 1'b0;
    vectors++;
    if (cr2 !== 1'b0 || sel2 !== 1'b1 || gv2 !== 2'b10) begin
      miscompares++; $display("[TB] FAIL busy_before_reset: got cr=%b sel=%0d gv=%b expected cr=0 sel=1 gv=10", cr2, sel2, gv2);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (cr2 !== 1'b0 || sel2 !== 1'b0 || gv2 !== 2'b00) begin
      miscompares++; $display("[TB] FAIL async_reset: got cr=%b sel=%0d gv=%b expected all 0", cr2, sel2, gv2);
    end
    tick();
    reset_n = 1'b1;
    tick();
    vectors++;
    if (cr2 !== 1'b1 || sel2 !== 1'b1) begin
      miscompares++; $display("[TB] FAIL first_decision: got cr=%b sel=%0d expected cr=1 sel=1", cr2, sel2);
    end
    cg2 = 1'b1; tok2 = 1'b1;
    tick();
    cg2 = 1'b0; tok2 = 1'b0; req2 = 2'b00;
  endtask

  task automatic test_qos_priority();
    req2 = 2'b11; qos2[0] = 4'd3; qos2[1] = 4'd9;
    tick();
    vectors++;
    if (sel2 !== 1'b1 || gv2 !== 2'b10 || cr2 !== 1'b1) begin
      miscompares++; $display("[TB] FAIL qos_win: got sel=%0d gv=%b cr=%b expected sel=1 gv=10 cr=1", sel2, gv2, cr2);
    end
    cg2 = 1'b1; tok2 = 1'b1;
    tick();
    cg2 = 1'b0; tok2 = 1'b0; req2 = 2'b00;
    vectors++;
    if (cr2 !== 1'b0 || gv2 !== 2'b00) begin
      miscompares++; $display("[TB] FAIL grant_token_same_cycle: got cr=%b gv=%b expected cr=0 gv=00", cr2, gv2);
    end
  endtask

  task automatic test_starvation();
    logic exp_w [3] = '{1'b0, 1'b0, 1'b1};
    qos2[0] = 4'd15; qos2[1] = 4'd0; req2 = 2'b11;
    for (int r = 0; r < 3; r++) begin
      tick();
      vectors++;
      if (sel2 !== exp_w[r] || cr2 !== 1'b1) begin
        miscompares++; $display("[TB] FAIL starve_round%0d: got sel=%0d cr=%b expected sel=%0d cr=1", r, sel2, cr2, exp_w[r]);
      end
      if (r == 1) begin
        vectors++;
        if (d2.starve_cnt[1] !== 2'd2) begin
          miscompares++; $display("[TB] FAIL starve_cnt_sat: got %0d expected 2", d2.starve_cnt[1]);
        end
      end
      if (r == 2) begin
        vectors++;
        if (d2.starve_cnt[1] !== 2'd0) begin
          miscompares++; $display("[TB] FAIL starve_cnt_clear: got %0d expected 0", d2.starve_cnt[1]);
        end
      end
      cg2 = 1'b1;
      tick();
      cg2 = 1'b0;
      tok2 = 1'b1;
      tick();
      tok2 = 1'b0;
    end
    req2 = 2'b00;
  endtask

  task automatic test_round_robin();
    int exp_w [5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 4; i++) qos4[i] = 4'd5;
    for (int r = 0; r < 5; r++) begin
      req4 = (r < 3) ? 4'b1111 : 4'b1001;
      tick();
      vectors++;
      if (sel4 !== 2'(exp_w[r]) || gv4 !== (4'b0001 << exp_w[r]) || cr4 !== 1'b1) begin
        miscompares++; $display("[TB] FAIL rr_round%0d: got sel=%0d gv=%b cr=%b expected sel=%0d cr=1", r, sel4, gv4, cr4, exp_w[r]);
      end
      cg4 = 1'b1;
      tick();
      cg4 = 1'b0;
      vectors++;
      if (cr4 !== 1'b0) begin
        miscompares++; $display("[TB] FAIL rr_busy%0d: got cr=%b expected 0", r, cr4);
      end
      tok4 = 1'b1;
      tick();
      tok4 = 1'b0;
      vectors++;
      if (gv4 !== 4'b0000) begin
        miscompares++; $display("[TB] FAIL rr_idle%0d: got gv=%b expected 0000", r, gv4);
      end
    end
    req4 = 4'b0000;
  endtask

  task automatic test_handshake();
    tok4 = 1'b1;
    tick();
    tok4 = 1'b0;
    vectors++;
    if (cr4 !== 1'b0 || gv4 !== 4'b0000) begin
      miscompares++; $display("[TB] FAIL token_in_idle: got cr=%b gv=%b expected cr=0 gv=0000", cr4, gv4);
    end
    req4 = 4'b0100;
    tick();
    vectors++;
    if (sel4 !== 2'd2 || cr4 !== 1'b1) begin
      miscompares++; $display("[TB] FAIL abort_setup: got sel=%0d cr=%b expected sel=2 cr=1", sel4, cr4);
    end
    req4 = 4'b0000;
    tick();
    vectors++;
    if (cr4 !== 1'b0 || gv4 !== 4'b0000) begin
      miscompares++; $display("[TB] FAIL abort_idle: got cr=%b gv=%b expected cr=0 gv=0000", cr4, gv4);
    end
    req4 = 4'b1111;
    tick();
    vectors++;
    if (sel4 !== 2'd1) begin
      miscompares++; $display("[TB] FAIL abort_rr_kept: got sel=%0d expected 1", sel4);
    end
    cg4 = 1'b1; tok4 = 1'b1;
    tick();
    cg4 = 1'b0; tok4 = 1'b0; req4 = 4'b0000;
    vectors++;
    if (cr4 !== 1'b0 || gv4 !== 4'b0000) begin
      miscompares++; $display("[TB] FAIL d4_grant_token: got cr=%b gv=%b expected cr=0 gv=0000", cr4, gv4);
    end
  endtask

  task automatic test_hold_stability();
    req4 = 4'b0001; qos4[0] = 4'd2;
    tick();
    cg4 = 1'b1;
    tick();
    cg4 = 1'b0;
    req4 = 4'b1110;
    for (int i = 0; i < 4; i++) qos4[i] = 4'd15;
    for (int c = 0; c < 3; c++) begin
      cg4 = (c == 1);
      tick();
      vectors++;
      if (sel4 !== 2'd0 || gv4 !== 4'b0001 || cr4 !== 1'b0) begin
        miscompares++; $display("[TB] FAIL hold_cycle%0d: got sel=%0d gv=%b cr=%b expected sel=0 gv=0001 cr=0", c, sel4, gv4, cr4);
      end
    end
    cg4 = 1'b0; tok4 = 1'b1;
    tick();
    tok4 = 1'b0; req4 = 4'b0000;
    vectors++;
    if (gv4 !== 4'b0000) begin
      miscompares++; $display("[TB] FAIL hold_release: got gv=%b expected 0000", gv4);
    end
  endtask

  initial begin
    test_reset();
    test_qos_priority();
    test_starvation();
    test_round_robin();
    test_handshake();
    test_hold_stability();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
